edge_event_scheduler: RTL and testbench

Multi-channel edge capture controller that sits between raw asynchronous inputs and the consuming logic. Each channel synchronises its input, detects edges according to a per-channel mode, and latches a timestamped pending event. A round-robin arbiter serialises the pending events into a small event FIFO, which is drained over a valid/ready interface. Per-channel overflow is reported when an edge arrives before the channel's previous event has been accepted.

---
 rtl/edge_sched_pkg.sv | 18 +
 rtl/edge_sched_chan.sv | 80 ++++++++
 rtl/edge_event_scheduler.sv | 142 ++++++++++++++
 tb/tb_edge_event_scheduler.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_sched_pkg.sv
// Shared constants and event-record layout for the edge event scheduler.
package edge_sched_pkg;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    // Event record, MSB to LSB: {ch, rise, ts}
    function automatic int unsigned evt_w(input int unsigned num_ch, input int unsigned ts_w);
        return $clog2(num_ch) + 1 + ts_w;
    endfunction

    function automatic int unsigned evt_rise_pos(input int unsigned ts_w);
        return ts_w;
    endfunction

endpackage

// File: rtl/edge_sched_chan.sv
// One capture channel: synchroniser, edge detect, pending-event latch and overflow flag.
module edge_sched_chan
    import edge_sched_pkg::*;
#(
    parameter int unsigned TS_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sig,
    input  logic [1:0]      mode,
    input  logic            armed,
    input  logic            grant,
    input  logic            ovf_clr,
    input  logic [TS_W-1:0] ts_now,
    output logic            pend,
    output logic            rise,
    output logic [TS_W-1:0] ts,
    output logic            ovf
);
    logic s0, s1, s2, prev;
    logic is_rise, is_fall, hit, ovf_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            s0   <= 1'b0;
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s0   <= sig;
            s1   <= s0;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign is_rise = s2 & ~prev;
    assign is_fall = ~s2 & prev;

    always_comb begin
        hit = 1'b0;
        if (armed) begin
            case (mode)
                MODE_RISE: hit = is_rise;
                MODE_FALL: hit = is_fall;
                MODE_BOTH: hit = is_rise | is_fall;
                default:   hit = 1'b0;
            endcase
        end
    end

    // A grant in the same cycle frees the slot, so the new edge is not an overflow.
    assign ovf_set = hit & pend & ~grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= 1'b0;
            rise <= 1'b0;
            ts   <= '0;
        end else if (mode == MODE_OFF) begin
            pend <= 1'b0;
        end else if (hit && (!pend || grant)) begin
            pend <= 1'b1;
            rise <= is_rise;
            ts   <= ts_now;
        end else if (grant) begin
            pend <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            ovf <= 1'b0;
        else if (ovf_set)
            ovf <= 1'b1;
        else if (ovf_clr)
            ovf <= 1'b0;
    end

endmodule

// File: rtl/edge_event_scheduler.sv
// Multi-channel edge capture with round-robin arbitration into a first-word-fall-through event FIFO.
module edge_event_scheduler
    import edge_sched_pkg::*;
#(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned TS_W       = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         sig_in,
    input  logic [2*NUM_CH-1:0]       cfg_mode,
    output logic                      evt_valid,
    input  logic                      evt_ready,
    output logic [$clog2(NUM_CH)-1:0] evt_ch,
    output logic                      evt_rise,
    output logic [TS_W-1:0]           evt_ts,
    output logic [NUM_CH-1:0]         ovf,
    input  logic [NUM_CH-1:0]         ovf_clr
);
    localparam int unsigned CH_W = $clog2(NUM_CH);
    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CW   = AW + 1;
    localparam int unsigned EW   = evt_w(NUM_CH, TS_W);
    localparam int unsigned RP   = evt_rise_pos(TS_W);
    localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [CW-1:0]   FULL_CNT = CW'(FIFO_DEPTH);

    logic [1:0]        arm_cnt;
    logic              armed;
    logic [TS_W-1:0]   ts_cnt;
    logic [NUM_CH-1:0] pend, rise_q, req, grant;
    logic [TS_W-1:0]   ts_q [NUM_CH];
    logic [CH_W-1:0]   rr_ptr, gnt_idx;
    logic              gnt_vld, gnt_fire;
    logic [EW-1:0]     mem [FIFO_DEPTH];
    logic [EW-1:0]     head, wdata;
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic              full, pop;

    // Detection stays off for four cycles after reset release.
    always_ff @(posedge clk) begin
        if (rst) begin
            arm_cnt <= 2'd0;
            armed   <= 1'b0;
        end else if (!armed) begin
            if (arm_cnt == 2'd3)
                armed <= 1'b1;
            else
                arm_cnt <= arm_cnt + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            ts_cnt <= '0;
        else
            ts_cnt <= ts_cnt + TS_W'(1);
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        edge_sched_chan #(.TS_W(TS_W)) u_chan (
            .clk     (clk),
            .rst     (rst),
            .sig     (sig_in[g]),
            .mode    (cfg_mode[2*g +: 2]),
            .armed   (armed),
            .grant   (grant[g]),
            .ovf_clr (ovf_clr[g]),
            .ts_now  (ts_cnt),
            .pend    (pend[g]),
            .rise    (rise_q[g]),
            .ts      (ts_q[g]),
            .ovf     (ovf[g])
        );
        assign req[g] = pend[g] & (cfg_mode[2*g +: 2] != MODE_OFF);
    end

    always_comb begin
        int unsigned j;
        j       = 0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            j = (32'(rr_ptr) + i) % NUM_CH;
            if (!gnt_vld && req[CH_W'(j)]) begin
                gnt_vld = 1'b1;
                gnt_idx = CH_W'(j);
            end
        end
    end

    assign full     = (count == FULL_CNT);
    assign pop      = evt_valid & evt_ready;
    assign gnt_fire = gnt_vld & (~full | pop);

    always_comb begin
        grant = '0;
        if (gnt_fire)
            grant[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            rr_ptr <= '0;
        else if (gnt_fire)
            rr_ptr <= (gnt_idx == LAST_CH) ? '0 : gnt_idx + CH_W'(1);
    end

    assign wdata = {gnt_idx, rise_q[gnt_idx], ts_q[gnt_idx]};

    always_ff @(posedge clk) begin
        if (gnt_fire)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (gnt_fire)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({gnt_fire, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign evt_valid = (count != '0);
    assign head      = mem[rd_ptr];
    assign evt_ch    = evt_valid ? head[EW-1 -: CH_W] : '0;
    assign evt_rise  = evt_valid & head[RP];
    assign evt_ts    = evt_valid ? head[TS_W-1:0] : '0;

endmodule

// File: tb/tb_edge_event_scheduler.sv
// Randomised and directed bench for edge_event_scheduler against a behavioural event model.
module tb_edge_event_scheduler;

    localparam int NCH   = 4;
    localparam int TSW   = 16;
    localparam int DEPTH = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] sig_in;
    logic [2*NCH-1:0] cfg_mode;
    logic           evt_ready;
    logic [NCH-1:0] ovf_clr;

    logic           evt_valid_a, evt_rise_a, evt_valid_b, evt_rise_b;
    logic [1:0]     evt_ch_a, evt_ch_b;
    logic [15:0]    evt_ts_a;
    logic [3:0]     evt_ts_b;
    logic [NCH-1:0] ovf_a, ovf_b;

    always #5 clk = ~clk;

    edge_event_scheduler #(.NUM_CH(NCH), .TS_W(TSW), .FIFO_DEPTH(DEPTH)) u_dut_a (
        .clk(clk), .rst(rst), .sig_in(sig_in), .cfg_mode(cfg_mode),
        .evt_valid(evt_valid_a), .evt_ready(evt_ready), .evt_ch(evt_ch_a),
        .evt_rise(evt_rise_a), .evt_ts(evt_ts_a), .ovf(ovf_a), .ovf_clr(ovf_clr)
    );

    // Narrow-timestamp copy sees identical stimulus; only its ts wraps at 16.
    edge_event_scheduler #(.NUM_CH(NCH), .TS_W(4), .FIFO_DEPTH(DEPTH)) u_dut_b (
        .clk(clk), .rst(rst), .sig_in(sig_in), .cfg_mode(cfg_mode),
        .evt_valid(evt_valid_b), .evt_ready(evt_ready), .evt_ch(evt_ch_b),
        .evt_rise(evt_rise_b), .evt_ts(evt_ts_b), .ovf(ovf_b), .ovf_clr(ovf_clr)
    );

    typedef struct packed {
        logic [1:0]  ch;
        logic        rise;
        logic [15:0] ts;
    } ev_t;

    ev_t            m_fifo[$];
    logic [NCH-1:0] hist[$];
    logic [NCH-1:0] m_pend, m_rise, m_ovf;
    logic [15:0]    m_ts [NCH];
    logic [15:0]    m_tsc;
    int unsigned    m_since, m_rr;
    int             total = 0;
    int             bad = 0;

    task automatic m_reset();
        m_fifo.delete();
        hist.delete();
        repeat (4) hist.push_back('0);
        m_pend  = '0;
        m_rise  = '0;
        m_ovf   = '0;
        for (int c = 0; c < NCH; c++) m_ts[c] = '0;
        m_tsc   = '0;
        m_since = 0;
        m_rr    = 0;
    endtask

    // Advance the reference by one clock using the inputs presented during that cycle.
    task automatic m_step();
        logic [NCH-1:0] s2, pv;
        logic [1:0]     md;
        bit             pop, gv, r, f, want, oset;
        int unsigned    g, c2;
        ev_t            e;
        if (rst) begin
            m_reset();
            return;
        end
        s2  = hist[2];
        pv  = hist[3];
        pop = (m_fifo.size() != 0) && evt_ready;
        gv  = 0;
        g   = 0;
        if (m_fifo.size() < DEPTH || pop) begin
            for (int k = 0; k < NCH; k++) begin
                c2 = (m_rr + k) % NCH;
                if (!gv && m_pend[c2] && cfg_mode[2*c2 +: 2] != 2'b00) begin
                    gv = 1;
                    g  = c2;
                end
            end
        end
        if (pop) void'(m_fifo.pop_front());
        if (gv) begin
            e.ch   = g[1:0];
            e.rise = m_rise[g];
            e.ts   = m_ts[g];
            m_fifo.push_back(e);
            m_rr = (g + 1) % NCH;
        end
        for (int c = 0; c < NCH; c++) begin
            md   = cfg_mode[2*c +: 2];
            r    = s2[c] & ~pv[c];
            f    = ~s2[c] & pv[c];
            want = (m_since >= 4) && ((md[0] && r) || (md[1] && f));
            oset = 0;
            if (md == 2'b00) begin
                m_pend[c] = 1'b0;
            end else if (want) begin
                if (m_pend[c] && !(gv && g == c)) begin
                    oset = 1;
                end else begin
                    m_pend[c] = 1'b1;
                    m_rise[c] = r;
                    m_ts[c]   = m_tsc;
                end
            end else if (gv && g == c) begin
                m_pend[c] = 1'b0;
            end
            if (oset) m_ovf[c] = 1'b1;
            else if (ovf_clr[c]) m_ovf[c] = 1'b0;
        end
        m_tsc = m_tsc + 16'd1;
        if (m_since < 4) m_since++;
        hist.push_front(sig_in);
        void'(hist.pop_back());
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        ev_t h;
        bit  v;
        v = (m_fifo.size() != 0);
        h = v ? m_fifo[0] : '0;
        chk("a_valid", evt_valid_a, v);
        chk("a_ch",    evt_ch_a,    h.ch);
        chk("a_rise",  evt_rise_a,  h.rise);
        chk("a_ts",    evt_ts_a,    h.ts);
        chk("a_ovf",   ovf_a,       m_ovf);
        chk("b_valid", evt_valid_b, v);
        chk("b_ch",    evt_ch_b,    h.ch);
        chk("b_rise",  evt_rise_b,  h.rise);
        chk("b_ts",    evt_ts_b,    h.ts[3:0]);
        chk("b_ovf",   ovf_b,       m_ovf);
    endtask

    task automatic tick();
        @(posedge clk);
        m_step();
        #1;
        check_all();
    endtask

    task automatic toggle0(input int times);
        for (int i = 0; i < times; i++) begin
            sig_in[0] = ~sig_in[0];
            repeat (3) tick();
        end
        repeat (4) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          n;
        int          ord [4];
        logic [15:0] t0;
        logic [3:0]  ta, tb;
        ord = '{2, 3, 0, 1};
        m_reset();
        rst = 1'b1; sig_in = 4'b0001; cfg_mode = 8'b00_00_00_01;
        evt_ready = 1'b0; ovf_clr = '0;
        repeat (3) tick();
        chk("rst_valid", evt_valid_a, 0);
        chk("rst_ch", evt_ch_a, 0);
        chk("rst_rise", evt_rise_a, 0);
        chk("rst_ts", evt_ts_a, 0);
        chk("rst_ovf", ovf_a, 0);
        rst = 1'b0;
        repeat (20) tick();
        chk("static_high", evt_valid_a, 0);

        sig_in[0] = 1'b0;
        repeat (6) tick();
        sig_in[0] = 1'b1;
        repeat (4) tick();
        chk("lat4_valid", evt_valid_a, 0);
        tick();
        chk("lat5_valid", evt_valid_a, 1);
        chk("lat5_ch", evt_ch_a, 0);
        chk("lat5_rise", evt_rise_a, 1);
        evt_ready = 1'b1; tick(); evt_ready = 1'b0;
        chk("single_event", evt_valid_a, 0);

        cfg_mode = 8'b00_00_10_01;
        sig_in[1] = 1'b1;
        repeat (6) tick();
        n = 0;
        while (m_tsc != 16'd97 && n < 2000) begin tick(); n++; end
        sig_in[1] = 1'b0;
        repeat (5) tick();
        chk("fall_valid", evt_valid_a, 1);
        chk("fall_ch", evt_ch_a, 1);
        chk("fall_rise", evt_rise_a, 0);
        chk("fall_ts", evt_ts_a, 100);
        chk("fall_ts4", evt_ts_b, 4);
        evt_ready = 1'b1; tick(); evt_ready = 1'b0;

        cfg_mode = 8'b00_00_11_01;
        sig_in[1] = 1'b1;
        repeat (4) tick();
        sig_in[1] = 1'b0;
        repeat (8) tick();
        chk("both1_ch", evt_ch_a, 1);
        chk("both1_rise", evt_rise_a, 1);
        evt_ready = 1'b1; tick(); evt_ready = 1'b0;
        chk("both2_valid", evt_valid_a, 1);
        chk("both2_rise", evt_rise_a, 0);
        evt_ready = 1'b1; tick(); evt_ready = 1'b0;
        chk("both_drained", evt_valid_a, 0);

        cfg_mode = 8'b01_01_01_01;
        sig_in = 4'b0000;
        repeat (6) tick();
        evt_ready = 1'b1;
        sig_in = 4'b1111;
        t0 = m_tsc + 16'd3;
        repeat (5) tick();
        for (int i = 0; i < 4; i++) begin
            chk("rr_valid", evt_valid_a, 1);
            chk("rr_ch", evt_ch_a, ord[i]);
            chk("rr_ts", evt_ts_a, t0);
            tick();
        end
        chk("rr_drained", evt_valid_a, 0);
        evt_ready = 1'b0;

        cfg_mode = 8'b00_00_00_11;
        sig_in = 4'b0000;
        repeat (6) tick();
        toggle0(10);
        chk("ovf_set", ovf_a, 4'b0001);
        evt_ready = 1'b1;
        n = 0;
        while (evt_valid_a && n < 20) begin tick(); n++; end
        chk("drain_count", n, 9);
        evt_ready = 1'b0;
        ovf_clr = 4'b0001; tick(); ovf_clr = '0;
        chk("ovf_clear", ovf_a, 0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) sig_in[$urandom_range(0, NCH-1)] ^= 1'b1;
            if ($urandom_range(0, 63) == 0) cfg_mode = 8'($urandom_range(0, 255));
            evt_ready = (i % 400 < 100) ? 1'b0 : ($urandom_range(0, 3) != 0);
            ovf_clr   = ($urandom_range(0, 15) == 0) ? 4'(1 << $urandom_range(0, NCH-1)) : '0;
            rst       = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0; ovf_clr = '0;

        cfg_mode = 8'b01_00_00_11;
        sig_in = 4'b0000;
        evt_ready = 1'b1;
        repeat (20) tick();
        evt_ready = 1'b0;
        toggle0(3);
        chk("pre_rst_valid", evt_valid_a, 1);
        rst = 1'b1; sig_in[3] = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_pulse_valid", evt_valid_a, 0);
        chk("rst_pulse_ovf", ovf_a, 0);
        repeat (16) tick();
        chk("arm_window", evt_valid_a, 0);

        cfg_mode = 8'b00_01_00_00;
        sig_in = 4'b0000;
        repeat (6) tick();
        sig_in[2] = 1'b1;
        repeat (6) tick();
        chk("wrap1_valid", evt_valid_b, 1);
        ta = evt_ts_b;
        evt_ready = 1'b1; tick(); evt_ready = 1'b0;
        sig_in[2] = 1'b0;
        repeat (6) tick();
        repeat (7) tick();
        sig_in[2] = 1'b1;
        repeat (6) tick();
        chk("wrap2_valid", evt_valid_b, 1);
        tb = evt_ts_b;
        chk("wrap_diff", tb - ta, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
